// File: rtl/qynq_led_ctrl.sv
// qynq_led_ctrl -- AXI4-Lite controlled LED driver.
//
// Each of NUM_CH channels runs in one of four modes (static, blink, pwm, off)
// clocked by a shared prescaler tick. Register map (word aligned):
//   0x00 GLOBAL   : bit0 enable (RW), bit1 restart (write-1 pulse, reads 0)
//   0x04 PRESCALE : bits[15:0] tick divider, tick every PRESCALE+1 clocks
//   0x08 STATUS   : bits[NUM_CH-1:0] current led_o (RO)
//   0x10+4*i CH_i : [1:0] mode, [2] level, [15:8] duty, [23:16] period
//
// Ports:
//   s_axi_aclk / s_axi_aresetn : clock, async active-low reset
//   s_axi_aw* / s_axi_w* / s_axi_b* : AXI4-Lite write address/data/response
//   s_axi_ar* / s_axi_r*            : AXI4-Lite read address/data
//   led_o                           : registered LED drive, one bit per channel

// Per-channel counter, blink state and LED output register.
module qynq_led_ch #(
    parameter logic RST_BIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       tick,     // prescaler tick, already gated by enable
    input  logic       clr,      // restart or mode change; beats tick
    input  logic [1:0] mode,
    input  logic       level,
    input  logic [7:0] duty,
    input  logic [7:0] period,
    output logic       led
);
    localparam logic [1:0] M_STATIC = 2'd0;
    localparam logic [1:0] M_BLINK  = 2'd1;
    localparam logic [1:0] M_PWM    = 2'd2;

    logic [7:0] cnt;
    logic       blink;
    logic       wrap;
    logic       led_nx;

    assign wrap = (cnt == period);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            blink <= 1'b0;
            led   <= RST_BIT;
        end else begin
            if (clr) begin
                cnt   <= '0;
                blink <= 1'b0;
            end else if (tick) begin
                cnt <= wrap ? 8'd0 : cnt + 8'd1;
                if (wrap) blink <= ~blink;
            end
            led <= led_nx;
        end
    end

    // duty > period naturally yields constant 1 (cnt never exceeds period),
    // duty == 0 yields constant 0.
    always_comb begin
        led_nx = 1'b0;
        if (!enable) begin
            led_nx = (mode == M_STATIC) && level;
        end else begin
            case (mode)
                M_STATIC: led_nx = level;
                M_BLINK:  led_nx = blink;
                M_PWM:    led_nx = (cnt < duty);
                default:  led_nx = 1'b0;
            endcase
        end
    end
endmodule

module qynq_led_ctrl #(
    parameter int                NUM_CH  = 4,
    parameter int                ADDR_W  = 8,
    parameter logic [NUM_CH-1:0] RST_VAL = '0
) (
    input  logic              s_axi_aclk,
    input  logic              s_axi_aresetn,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic [NUM_CH-1:0] led_o
);
    localparam int         IDX_W  = ADDR_W - 2;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef struct packed {
        logic [7:0] period;
        logic [7:0] duty;
        logic       level;
        logic [1:0] mode;
    } ch_cfg_t;

    logic                   enable;
    logic [15:0]            prescale;
    logic [15:0]            pre_cnt;
    logic                   tick;
    logic                   restart;
    ch_cfg_t [NUM_CH-1:0]   ch_cfg;
    logic [NUM_CH-1:0]      ch_clr;

    logic [IDX_W-1:0]       aw_idx, ar_idx;
    logic                   wr_glb, wr_pre, wr_sts;
    logic [NUM_CH-1:0]      wr_ch;
    logic                   wr_ok;
    logic                   wr_fire, wr_hs;
    logic                   ar_fire, ar_hs;
    logic [31:0]            rd_val;
    logic                   rd_ok;

    assign aw_idx = s_axi_awaddr[ADDR_W-1:2];
    assign ar_idx = s_axi_araddr[ADDR_W-1:2];

    // ---------------- write channel ----------------
    // awready/wready are one registered pulse; the master holds AW/W valid
    // until that pulse, so address and data are sampled in the pulse cycle.
    assign wr_fire      = s_axi_awvalid & s_axi_wvalid & ~s_axi_awready & ~s_axi_bvalid;
    assign wr_hs        = s_axi_awready & s_axi_awvalid & s_axi_wvalid;
    assign s_axi_wready = s_axi_awready;

    always_comb begin
        wr_glb = (aw_idx == IDX_W'(0));
        wr_pre = (aw_idx == IDX_W'(1));
        wr_sts = (aw_idx == IDX_W'(2));
        for (int i = 0; i < NUM_CH; i++) wr_ch[i] = (aw_idx == IDX_W'(4 + i));
        wr_ok = wr_glb | wr_pre | wr_sts | (|wr_ch);
    end

    assign restart = wr_hs & wr_glb & s_axi_wstrb[0] & s_axi_wdata[1];

    always_comb begin
        for (int i = 0; i < NUM_CH; i++)
            ch_clr[i] = restart |
                        (wr_hs & wr_ch[i] & s_axi_wstrb[0] & (s_axi_wdata[1:0] != ch_cfg[i].mode));
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            s_axi_awready <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= OKAY;
            enable        <= 1'b0;
            prescale      <= '0;
            ch_cfg        <= '0;
        end else begin
            s_axi_awready <= wr_fire;
            if (wr_hs) begin
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= wr_ok ? OKAY : SLVERR;
            end else if (s_axi_bvalid && s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
            end

            if (wr_hs && wr_glb && s_axi_wstrb[0]) enable <= s_axi_wdata[0];
            if (wr_hs && wr_pre) begin
                if (s_axi_wstrb[0]) prescale[7:0]  <= s_axi_wdata[7:0];
                if (s_axi_wstrb[1]) prescale[15:8] <= s_axi_wdata[15:8];
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_hs && wr_ch[i]) begin
                    if (s_axi_wstrb[0]) {ch_cfg[i].level, ch_cfg[i].mode} <= s_axi_wdata[2:0];
                    if (s_axi_wstrb[1]) ch_cfg[i].duty   <= s_axi_wdata[15:8];
                    if (s_axi_wstrb[2]) ch_cfg[i].period <= s_axi_wdata[23:16];
                end
            end
        end
    end

    // ---------------- prescaler ----------------
    assign tick = enable & (pre_cnt == prescale);

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn)  pre_cnt <= '0;
        else if (restart)    pre_cnt <= '0;
        else if (enable)     pre_cnt <= tick ? 16'd0 : pre_cnt + 16'd1;
    end

    // ---------------- channels ----------------
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        qynq_led_ch #(.RST_BIT(RST_VAL[g])) u_ch (
            .clk    (s_axi_aclk),
            .rst_n  (s_axi_aresetn),
            .enable (enable),
            .tick   (tick),
            .clr    (ch_clr[g]),
            .mode   (ch_cfg[g].mode),
            .level  (ch_cfg[g].level),
            .duty   (ch_cfg[g].duty),
            .period (ch_cfg[g].period),
            .led    (led_o[g])
        );
    end

    // ---------------- read channel ----------------
    assign ar_fire = s_axi_arvalid & ~s_axi_arready & ~s_axi_rvalid;
    assign ar_hs   = s_axi_arready & s_axi_arvalid;

    always_comb begin
        rd_val = '0;
        rd_ok  = 1'b0;
        if (ar_idx == IDX_W'(0)) begin
            rd_val[0] = enable;
            rd_ok     = 1'b1;
        end else if (ar_idx == IDX_W'(1)) begin
            rd_val[15:0] = prescale;
            rd_ok        = 1'b1;
        end else if (ar_idx == IDX_W'(2)) begin
            rd_val[NUM_CH-1:0] = led_o;
            rd_ok              = 1'b1;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (ar_idx == IDX_W'(4 + i)) begin
                rd_val = {8'h00, ch_cfg[i].period, ch_cfg[i].duty, 5'b0,
                          ch_cfg[i].level, ch_cfg[i].mode};
                rd_ok  = 1'b1;
            end
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= OKAY;
        end else begin
            s_axi_arready <= ar_fire;
            if (ar_hs) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= rd_val;
                s_axi_rresp  <= rd_ok ? OKAY : SLVERR;
            end else if (s_axi_rvalid && s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/qynq_led_ctrl.md
QYNQ_LED_CTRL -- requirements
Module: qynq_led_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of LED channels (legal 1..16).
REQ-002 SHALL have parameter ADDR_W, default 8, meaning AXI4-Lite byte-address width.
REQ-003 SHALL have parameter RST_VAL, default 0, meaning led_o value after reset (NUM_CH bits).
REQ-004 SHALL have port s_axi_aclk, input, 1, the single clock for all logic.
REQ-005 SHALL have port s_axi_aresetn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports s_axi_awaddr (in, ADDR_W), s_axi_awvalid (in, 1) and s_axi_awready (out, 1), the write-address channel.
REQ-007 SHALL have ports s_axi_wdata (in, 32), s_axi_wstrb (in, 4), s_axi_wvalid (in, 1) and s_axi_wready (out, 1), the write-data channel.
REQ-008 SHALL have ports s_axi_bresp (out, 2), s_axi_bvalid (out, 1) and s_axi_bready (in, 1), the write-response channel.
REQ-009 SHALL have ports s_axi_araddr (in, ADDR_W), s_axi_arvalid (in, 1) and s_axi_arready (out, 1), the read-address channel.
REQ-010 SHALL have ports s_axi_rdata (out, 32), s_axi_rresp (out, 2), s_axi_rvalid (out, 1) and s_axi_rready (in, 1), the read-data channel.
REQ-011 SHALL have port led_o, output, NUM_CH, registered LED drive.

Function
REQ-012 SHALL map registers as: 0x00 GLOBAL (RW) -- bit0 enable, bit1 restart, write-1 self-clearing, reads 0; 0x04 PRESCALE (RW, bits[15:0]); 0x08 STATUS (RO) -- bits[NUM_CH-1:0] = led_o; 0x10+4*i CH_i (RW) for i < NUM_CH.
REQ-013 SHALL define CH_i fields as: [1:0] mode (0 static, 1 blink, 2 pwm, 3 off); [2] static level; [15:8] duty; [23:16] period. Unused bits SHALL read 0.
REQ-014 SHALL accept a write only when awvalid and wvalid are both high: awready and wready pulse together for 1 cycle, and bvalid asserts the following cycle and holds until bready.
REQ-015 SHALL NOT accept a new AW/W or AR while bvalid or rvalid respectively is pending.
REQ-016 SHALL pulse arready for 1 cycle on arvalid, assert rvalid with rdata the next cycle, and hold both until rready.
REQ-017 SHALL return SLVERR (2'b10) for unmapped or CH_i with i >= NUM_CH, ignoring the write and reading 0; mapped accesses SHALL return OKAY.
REQ-018 SHALL honour wstrb per byte lane on all RW registers.
REQ-019 SHALL run a 16-bit prescaler while enable=1, producing a 1-cycle tick every PRESCALE+1 clocks (PRESCALE=0 gives a tick every clock).
REQ-020 SHALL give each channel an 8-bit counter cnt_i that advances on tick and wraps to 0 after reaching period (period=0 holds cnt_i at 0).
REQ-021 SHALL compute the next led_o[i] as: static -> level; blink -> toggle on each tick where cnt_i==period; pwm -> (cnt_i < duty); off -> 0. led_o[i] SHALL be registered, 1-cycle latency.
REQ-022 SHALL treat duty > period in pwm mode as constant 1, and duty=0 as constant 0.
REQ-023 SHALL, when enable=0, freeze prescaler and counters, and drive led_o to the static level of static-mode channels and 0 for all other channels.
REQ-024 SHALL, on a restart write, clear the prescaler, all cnt_i and blink states in the same cycle as the write handshake; restart SHALL take priority over a coincident tick.
REQ-025 SHALL clear cnt_i and the blink state when a write changes CH_i mode.

Reset
REQ-026 SHALL, on s_axi_aresetn low, immediately clear all ready/valid outputs, set bresp/rresp/rdata to 0, set GLOBAL, PRESCALE and all CH_i to 0, clear counters, and set led_o=RST_VAL.
REQ-027 SHALL abandon any in-flight transaction on reset, with no response issued afterwards.

Verification
REQ-028 SHALL be verified for static mode: write CH_0=0x4, GLOBAL=1 -> led_o[0]=1 two cycles after bvalid; STATUS reads 0x1.
REQ-029 SHALL be verified for blink: PRESCALE=0, CH_1 mode=1 period=3, enable -> led_o[1] toggles every 4 clocks.
REQ-030 SHALL be verified for pwm: PRESCALE=1, period=9, duty=3 -> led_o high 6 of every 20 clocks; duty=12 -> constant 1.
REQ-031 SHALL be verified for handshakes: AW before W by 3 cycles -> single write, OKAY; write to 0x40 with NUM_CH=4 -> SLVERR, no state change; bready held low 5 cycles -> bvalid holds and no new accept.
REQ-032 SHALL be verified for restart: restart written mid-period -> all cnt_i=0 next cycle, and the blink phase realigns across channels.
REQ-033 SHALL be verified for reset mid-read: aresetn low while rvalid=1 -> rvalid=0 immediately, led_o=RST_VAL, and all registers read 0 after release.
